if_id_queue: RTL and testbench

//  Parametrised IF/ID decoupling buffer: a DEPTH-entry FIFO of {pc, instr}

---
 rtl/if_id_queue.sv | 80 ++++++++
 tb/tb_if_id_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry FIFO of {pc, instr} between fetch and decode.
// An empty queue presents pc=0 and a NOP so decode always sees a harmless word.
module if_id_queue #(
  parameter int unsigned     XLEN  = 32,
  parameter int unsigned     ILEN  = 32,
  parameter int unsigned     DEPTH = 4,
  parameter logic [ILEN-1:0] NOP   = ILEN'(32'h00000013)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       if_valid_i,
  input  logic [XLEN-1:0]            if_pc_i,
  input  logic [ILEN-1:0]            if_instr_i,
  output logic                       if_ready_o,
  output logic                       id_valid_o,
  output logic [XLEN-1:0]            id_pc_o,
  output logic [ILEN-1:0]            id_instr_o,
  input  logic                       id_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [ILEN-1:0]  instr_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cur,
                                                  input logic inc,
                                                  input logic dec);
    next_count = cur + CNT_W'(inc) - CNT_W'(dec);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    // DEPTH is a power of two, so natural overflow gives the modulo wrap.
    ptr_inc = ptr + PTR_W'(1);
  endfunction

  // Ready depends only on state, so a full queue refuses even when popping.
  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign if_ready_o = !full;
  assign id_valid_o = !empty;
  assign push       = if_valid_i && if_ready_o;
  assign pop        = id_valid_o && id_ready_i;
  assign count_o    = count;

  assign id_pc_o    = empty ? '0  : pc_mem[rd_ptr];
  assign id_instr_o = empty ? NOP : instr_mem[rd_ptr];

  // Control state: reset and flush both return the queue to empty.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= next_count(count, push, pop);
    end
  end

  // Storage is never cleared; a push in a reset or flush cycle is dropped.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush_i) begin
      pc_mem[wr_ptr]    <= if_pc_i;
      instr_mem[wr_ptr] <= if_instr_i;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vectors plus a scoreboard monitor that
// predicts acceptance and compares every head presented to decode.
module tb_if_id_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        if_valid_i = 1'b0;
  logic [31:0] if_pc_i = '0;
  logic [31:0] if_instr_i = '0;
  logic        if_ready_o;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic        id_ready_i = 1'b0;
  logic [2:0]  count_o;

  if_id_queue #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_instr_i(if_instr_i),
    .if_ready_o(if_ready_o), .id_valid_o(id_valid_o), .id_pc_o(id_pc_o),
    .id_instr_o(id_instr_o), .id_ready_i(id_ready_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } entry_t;
  entry_t      exp_q[$];
  logic [31:0] pop_log[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          model_ok = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    instr_of = pc ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc);
    if_valid_i = v;
    if_pc_i    = pc;
    if_instr_i = instr_of(pc);
  endtask

  task automatic check_empty(input string tag);
    chk({tag, "_count"}, 64'(count_o), 64'd0);
    chk({tag, "_id_valid"}, 64'(id_valid_o), 64'd0);
    chk({tag, "_id_pc"}, 64'(id_pc_o), 64'd0);
    chk({tag, "_id_instr"}, 64'(id_instr_o), 64'(32'h13));
    chk({tag, "_if_ready"}, 64'(if_ready_o), 64'd1);
  endtask

  // Monitor: compare DUT against the model state, then advance the model.
  always @(negedge clk) begin
    bit do_push, do_pop;
    if (model_ok) begin
      chk("mon_count", 64'(count_o), 64'(exp_q.size()));
      chk("mon_if_ready", 64'(if_ready_o), 64'(exp_q.size() != DEPTH));
      chk("mon_id_valid", 64'(id_valid_o), 64'(exp_q.size() != 0));
      if (exp_q.size() == 0) begin
        chk("mon_empty_pc", 64'(id_pc_o), 64'd0);
        chk("mon_empty_instr", 64'(id_instr_o), 64'(NOP));
      end else begin
        chk("mon_head_pc", 64'(id_pc_o), 64'(exp_q[0].pc));
        chk("mon_head_instr", 64'(id_instr_o), 64'(exp_q[0].instr));
      end
    end
    if (rst) begin
      exp_q.delete();
      model_ok = 1;
    end else if (model_ok) begin
      if (flush_i) begin
        exp_q.delete();
      end else begin
        do_pop  = (exp_q.size() != 0) && id_ready_i;
        do_push = if_valid_i && (exp_q.size() != DEPTH);
        if (do_pop) begin
          pop_log.push_back(exp_q[0].pc);
          void'(exp_q.pop_front());
        end
        if (do_push) exp_q.push_back('{pc: if_pc_i, instr: if_instr_i});
      end
    end
  end

  initial begin
    logic [31:0] exp3[5];
    bit acc;
    int sent;
    int guard;

    // Test 1: reset
    rst = 1'b1;
    step();
    step();
    check_empty("t1_reset");
    rst = 1'b0;

    // Test 2: fill with decode stalled, fifth offer refused
    id_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'(i * 4));
      step();
    end
    offer(1'b1, 32'h10);
    step();
    step();
    chk("t2_count_full", 64'(count_o), 64'd4);
    chk("t2_if_ready", 64'(if_ready_o), 64'd0);
    chk("t2_head_held", 64'(id_pc_o), 64'h0);
    chk("t2_head_instr", 64'(id_instr_o), 64'(instr_of(32'h0)));

    // Test 3: pop from full, then push+pop steady at DEPTH-1
    pop_log.delete();
    id_ready_i = 1'b1;
    step();
    chk("t3_after_pop", 64'(count_o), 64'd3);
    chk("t3_head", 64'(id_pc_o), 64'h4);
    step();
    chk("t3_steady", 64'(count_o), 64'd3);
    offer(1'b0, 32'h0);
    guard = 0;
    while (count_o != 0 && guard < 20) begin
      step();
      guard++;
    end
    chk("t3_drain_timeout", 64'(guard < 20), 64'd1);
    exp3 = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
    chk("t3_pop_count", 64'(pop_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < pop_log.size(); i++)
      chk("t3_order", 64'(pop_log[i]), 64'(exp3[i]));

    // Test 4: random handshakes over 3*DEPTH entries
    pop_log.delete();
    sent = 0;
    acc = 0;
    offer(1'b0, 32'h100);
    for (int cyc = 0; cyc < 400 && pop_log.size() < 3 * DEPTH; cyc++) begin
      if (!if_valid_i || acc)
        offer((sent < 3 * DEPTH) && ($urandom_range(0, 3) != 0), 32'h100 + 32'(sent * 4));
      id_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = if_valid_i && if_ready_o;
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    offer(1'b0, 32'h0);
    id_ready_i = 1'b0;
    chk("t4_pop_count", 64'(pop_log.size()), 64'(3 * DEPTH));
    for (int i = 0; i < pop_log.size(); i++)
      chk("t4_order", 64'(pop_log[i]), 64'(32'h100 + 32'(i * 4)));

    // Test 5: flush a full queue with push and pop offered
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'h20 + 32'(i * 4));
      step();
    end
    chk("t5_full", 64'(count_o), 64'd4);
    flush_i = 1'b1;
    offer(1'b1, 32'h40);
    id_ready_i = 1'b1;
    step();
    flush_i = 1'b0;
    offer(1'b0, 32'h0);
    id_ready_i = 1'b0;
    check_empty("t5_flush");
    offer(1'b1, 32'h80);
    step();
    offer(1'b0, 32'h0);
    chk("t5_new_head", 64'(id_pc_o), 64'h80);
    chk("t5_new_count", 64'(count_o), 64'd1);

    // Test 6: reset mid-operation, then reset with flush
    offer(1'b1, 32'h84);
    step();
    offer(1'b0, 32'h0);
    chk("t6_count2", 64'(count_o), 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_empty("t6_rst");
    offer(1'b1, 32'h90);
    step();
    offer(1'b1, 32'h94);
    step();
    offer(1'b0, 32'h0);
    chk("t6_refill", 64'(count_o), 64'd2);
    rst = 1'b1;
    flush_i = 1'b1;
    step();
    rst = 1'b0;
    flush_i = 1'b0;
    check_empty("t6_rst_flush");
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
